// File: rtl/miner_pkg.sv
// Shared widths, state encoding and result packing for the miner job scheduler.
package miner_pkg;

    localparam int HASH_W  = 256;
    localparam int NONCE_W = 32;
    localparam int BLOCK_W = 608;
    localparam int JOB_W   = 864;
    localparam int TX_W    = 288;

    // Hash value reported when the whole nonce space was searched without a hit.
    localparam logic [HASH_W-1:0] EXHAUSTED_HASH = {HASH_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        RUN      = 2'd2,
        REPORT   = 2'd3
    } sched_state_t;

    // Result word layout on the transmit path: hash in the upper bits, nonce below.
    function automatic logic [TX_W-1:0] pack_result(input logic [HASH_W-1:0]  hash,
                                                    input logic [NONCE_W-1:0] nonce);
        return {hash, nonce};
    endfunction

endpackage

// File: rtl/miner_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer; the pointer moves one past the winner whenever the grant is used.
module miner_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic [IDX_W-1:0] cand_s;
    logic             take_s;

    // Scan requesters starting at the priority pointer, keep the first hit
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_s      = '0;
        take_s      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s      = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
            take_s      = !grant_valid && req[cand_s];
            grant_idx   = take_s ? cand_s : grant_idx;
            grant_valid = grant_valid | take_s;
        end
    end

    // Rotate priority past the winner when the caller consumes the grant
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            ptr_r <= '0;
        end else if (advance) begin
            ptr_r <= IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/miner_job_scheduler.sv
// Job scheduler: latches one job, deals nonce chunks to idle hashing cores,
// and reports the first winning result (or exhaustion) on a valid/ready port.
module miner_job_scheduler
    import miner_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int CHUNK_LOG2 = 24
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [JOB_W-1:0]             rx_data,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic                         host_abort,
    output logic [BLOCK_W-1:0]           job_block,
    output logic [HASH_W-1:0]            job_target,
    output logic [NUM_CORES-1:0]         core_start,
    output logic [NUM_CORES*NONCE_W-1:0] core_base,
    output logic                         core_abort,
    input  logic [NUM_CORES-1:0]         core_done,
    input  logic [NUM_CORES-1:0]         core_found,
    input  logic [NUM_CORES*HASH_W-1:0]  core_hash,
    input  logic [NUM_CORES*NONCE_W-1:0] core_nonce,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [TX_W-1:0]              tx_data
);

    localparam int                 CNT_W      = NONCE_W - CHUNK_LOG2;
    localparam int                 IDX_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [NONCE_W-1:0] CHUNK_STEP = NONCE_W'(64'd1 << CHUNK_LOG2);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    sched_state_t                 state_r, state_s;
    logic [NUM_CORES-1:0]         busy_r, busy_s;
    logic [NONCE_W-1:0]           next_base_r, next_base_s;
    logic [CNT_W-1:0]             chunk_cnt_r, chunk_cnt_s;
    logic                         chunks_left_r, chunks_left_s;
    logic [BLOCK_W-1:0]           job_block_r, job_block_s;
    logic [HASH_W-1:0]            job_target_r, job_target_s;
    logic [NUM_CORES-1:0]         core_start_r, core_start_s;
    logic [NUM_CORES*NONCE_W-1:0] core_base_r, core_base_s;
    logic                         core_abort_r, core_abort_s;
    logic                         job_ready_r, job_ready_s;
    logic                         tx_valid_r, tx_valid_s;
    logic [TX_W-1:0]              tx_data_r, tx_data_s;

    logic                         active_s;
    logic [NUM_CORES-1:0]         found_req_s;
    logic [NUM_CORES-1:0]         retire_s;
    logic [NUM_CORES-1:0]         issue_s;
    logic                         issue_hit_s;
    logic                         win_valid_s;
    logic [IDX_W-1:0]             win_idx_s;
    logic                         win_adv_s;

    // Only busy cores of a running job can retire or claim a win
    always_comb begin
        active_s    = (state_r == DISPATCH) || (state_r == RUN);
        found_req_s = active_s ? (core_done & core_found & busy_r) : '0;
        retire_s    = busy_r & ~core_done;
        win_adv_s   = active_s && !host_abort && win_valid_s;
    end

    // Lowest-index core that is idle once this cycle's completions are cleared
    always_comb begin
        issue_s     = '0;
        issue_hit_s = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            issue_s[i]  = !issue_hit_s && !retire_s[i];
            issue_hit_s = issue_hit_s | !retire_s[i];
        end
    end

    miner_rr_arbiter #(
        .NUM_REQ (NUM_CORES)
    ) u_found_arb (
        .clk         (clk),
        .n_rst       (n_rst),
        .req         (found_req_s),
        .advance     (win_adv_s),
        .grant_valid (win_valid_s),
        .grant_idx   (win_idx_s)
    );

    // Scheduler FSM: next state, chunk bookkeeping and next output values
    always_comb begin
        state_s       = state_r;
        busy_s        = busy_r;
        next_base_s   = next_base_r;
        chunk_cnt_s   = chunk_cnt_r;
        chunks_left_s = chunks_left_r;
        job_block_s   = job_block_r;
        job_target_s  = job_target_r;
        core_start_s  = '0;
        core_base_s   = core_base_r;
        core_abort_s  = 1'b0;
        job_ready_s   = job_ready_r;
        tx_valid_s    = tx_valid_r;
        tx_data_s     = tx_data_r;
        case (state_r)
            IDLE: begin
                job_ready_s = 1'b1;
                if (job_valid) begin
                    job_block_s   = rx_data[JOB_W-1:HASH_W];
                    job_target_s  = rx_data[HASH_W-1:0];
                    next_base_s   = '0;
                    chunk_cnt_s   = '0;
                    chunks_left_s = 1'b1;
                    busy_s        = '0;
                    job_ready_s   = 1'b0;
                    state_s       = DISPATCH;
                end else begin
                    state_s = IDLE;
                end
            end
            DISPATCH, RUN: begin
                if (host_abort) begin
                    core_abort_s = 1'b1;
                    busy_s       = '0;
                    tx_valid_s   = 1'b0;
                    tx_data_s    = '0;
                    job_ready_s  = 1'b1;
                    state_s      = IDLE;
                end else if (win_valid_s) begin
                    // A find beats exhaustion even if it retires the last busy core
                    tx_data_s    = pack_result(core_hash[win_idx_s*HASH_W +: HASH_W],
                                               core_nonce[win_idx_s*NONCE_W +: NONCE_W]);
                    tx_valid_s   = 1'b1;
                    core_abort_s = 1'b1;
                    busy_s       = '0;
                    state_s      = REPORT;
                end else if (chunks_left_r) begin
                    busy_s = retire_s | issue_s;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (issue_s[i]) begin
                            core_base_s[i*NONCE_W +: NONCE_W] = next_base_r;
                        end else begin
                            core_base_s[i*NONCE_W +: NONCE_W] = core_base_r[i*NONCE_W +: NONCE_W];
                        end
                    end
                    if (issue_hit_s) begin
                        core_start_s  = issue_s;
                        next_base_s   = next_base_r + CHUNK_STEP;
                        chunk_cnt_s   = chunk_cnt_r + CNT_W'(1);
                        chunks_left_s = (chunk_cnt_r != CNT_MAX);
                        state_s       = RUN;
                    end else begin
                        state_s = state_r;
                    end
                end else if (retire_s == '0) begin
                    busy_s     = '0;
                    tx_data_s  = pack_result(EXHAUSTED_HASH, NONCE_W'(0));
                    tx_valid_s = 1'b1;
                    state_s    = REPORT;
                end else begin
                    busy_s = retire_s;
                end
            end
            REPORT: begin
                if (host_abort) begin
                    core_abort_s = 1'b1;
                    busy_s       = '0;
                    tx_valid_s   = 1'b0;
                    tx_data_s    = '0;
                    job_ready_s  = 1'b1;
                    state_s      = IDLE;
                end else if (tx_ready) begin
                    tx_valid_s  = 1'b0;
                    tx_data_s   = '0;
                    job_ready_s = 1'b1;
                    state_s     = IDLE;
                end else begin
                    state_s = REPORT;
                end
            end
            default: begin
                busy_s      = '0;
                tx_valid_s  = 1'b0;
                job_ready_s = 1'b1;
                state_s     = IDLE;
            end
        endcase
    end

    // Register every state bit and output; reset leaves only job_ready high
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r       <= IDLE;
            busy_r        <= '0;
            next_base_r   <= '0;
            chunk_cnt_r   <= '0;
            chunks_left_r <= 1'b0;
            job_block_r   <= '0;
            job_target_r  <= '0;
            core_start_r  <= '0;
            core_base_r   <= '0;
            core_abort_r  <= 1'b0;
            job_ready_r   <= 1'b1;
            tx_valid_r    <= 1'b0;
            tx_data_r     <= '0;
        end else begin
            state_r       <= state_s;
            busy_r        <= busy_s;
            next_base_r   <= next_base_s;
            chunk_cnt_r   <= chunk_cnt_s;
            chunks_left_r <= chunks_left_s;
            job_block_r   <= job_block_s;
            job_target_r  <= job_target_s;
            core_start_r  <= core_start_s;
            core_base_r   <= core_base_s;
            core_abort_r  <= core_abort_s;
            job_ready_r   <= job_ready_s;
            tx_valid_r    <= tx_valid_s;
            tx_data_r     <= tx_data_s;
        end
    end

    assign job_ready  = job_ready_r;
    assign job_block  = job_block_r;
    assign job_target = job_target_r;
    assign core_start = core_start_r;
    assign core_base  = core_base_r;
    assign core_abort = core_abort_r;
    assign tx_valid   = tx_valid_r;
    assign tx_data    = tx_data_r;

endmodule
